// File: rtl/cmd_stream_pkg.sv
// Shared constants, FSM state type and width helpers for the command stream arbiter.
package cmd_stream_pkg;

    localparam logic [15:0] DEF_SYNC_WORD = 16'h817E;
    localparam logic [15:0] DEF_IDLE_WORD = 16'hAAAA;

    typedef enum logic {
        SLOT  = 1'b0,
        FRAME = 1'b1
    } arb_state_e;

    // Bits needed to hold the value n itself (counts that reach their maximum).
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Bits needed to index n items, never less than one.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cmd_fifo_sync.sv
// Single-clock command FIFO with registered full/empty flags and an occupancy count.
module cmd_fifo_sync
    import cmd_stream_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                          clk40,
    input  logic                          rst,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [DATA_W-1:0]             wdata_i,
    output logic [DATA_W-1:0]             rdata_o,
    output logic [cnt_width(DEPTH)-1:0]   count_o,
    output logic                          full_o,
    output logic                          empty_o
);

    localparam int AW = idx_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [DATA_W-1:0] mem_q [2**AW];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, empty_q;
    logic              push_ok, pop_ok;

    // Full is the registered flag, so a same-cycle pop never admits a write.
    assign push_ok = push_i & ~full_q;
    assign pop_ok  = pop_i & ~empty_q;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk40) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk40 or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/cmd_stream_arbiter.sv
// Round-robin, frame-atomic command arbiter with periodic SYNC and IDLE fill.
// States: SLOT | pick SYNC, a new grant or IDLE each slot;  FRAME | finish the granted frame
module cmd_stream_arbiter
    import cmd_stream_pkg::*;
#(
    parameter int                NUM_CH      = 4,
    parameter int                DATA_W      = 16,
    parameter int                FIFO_DEPTH  = 16,
    parameter int                FRAME_LEN   = 1,
    parameter int                SYNC_PERIOD = 32,
    parameter logic [DATA_W-1:0] SYNC_WORD   = DATA_W'(DEF_SYNC_WORD),
    parameter logic [DATA_W-1:0] IDLE_WORD   = DATA_W'(DEF_IDLE_WORD)
) (
    input  logic                     clk40,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        wr_cmd_i,
    input  logic [NUM_CH*DATA_W-1:0] datain_i,
    input  logic [NUM_CH-1:0]        ch_enable_i,
    input  logic                     ovf_clr_i,
    output logic [NUM_CH-1:0]        fifo_full_o,
    output logic [NUM_CH-1:0]        fifo_empty_o,
    output logic [NUM_CH-1:0]        overflow_o,
    output logic [DATA_W-1:0]        word_out_o,
    output logic                     word_valid_o,
    input  logic                     word_ready_i
);

    localparam int CH_W = idx_width(NUM_CH);
    localparam int CW   = cnt_width(FIFO_DEPTH);
    localparam int BW   = cnt_width(FRAME_LEN);
    localparam int SW   = idx_width(SYNC_PERIOD);

    logic [DATA_W-1:0] head [NUM_CH];
    logic [CW-1:0]     count [NUM_CH];
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] pop;

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [SW-1:0]     sync_cnt_q, sync_cnt_d;
    logic              sync_pend_q, sync_pend_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              valid_q;
    logic [NUM_CH-1:0] ovf_q, ovf_d;

    logic              slot;
    logic              pick_found;
    logic [CH_W-1:0]   pick_idx;
    logic              pend_clr;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cmd_fifo_sync #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk40   (clk40),
            .rst     (rst),
            .push_i  (wr_cmd_i[i]),
            .pop_i   (pop[i]),
            .wdata_i (datain_i[i*DATA_W +: DATA_W]),
            .rdata_o (head[i]),
            .count_o (count[i]),
            .full_o  (fifo_full_o[i]),
            .empty_o (fifo_empty_o[i])
        );

        // A channel is only eligible once a whole frame is already stored.
        assign elig[i] = ch_enable_i[i] & (count[i] >= CW'(FRAME_LEN));
    end

    assign slot = valid_q & word_ready_i;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!pick_found && elig[CH_W'((int'(rr_ptr_q) + k) % NUM_CH)]) begin
                pick_found = 1'b1;
                pick_idx   = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        beat_d      = beat_q;
        sync_cnt_d  = sync_cnt_q;
        sync_pend_d = sync_pend_q;
        word_d      = word_q;
        pop         = '0;
        pend_clr    = 1'b0;

        if (slot) begin
            sync_cnt_d = (sync_cnt_q == SW'(SYNC_PERIOD - 1)) ? '0 : sync_cnt_q + 1'b1;

            case (state_q)
                SLOT: begin
                    if (sync_pend_q) begin
                        word_d   = SYNC_WORD;
                        pend_clr = 1'b1;
                    end else if (pick_found) begin
                        word_d        = head[pick_idx];
                        pop[pick_idx] = 1'b1;
                        rr_ptr_d      = pick_idx;
                        beat_d        = BW'(1);
                        if (FRAME_LEN > 1) begin
                            state_d = FRAME;
                        end
                    end else begin
                        word_d = IDLE_WORD;
                    end
                end
                FRAME: begin
                    // A due SYNC waits here; the frame is never split or aborted.
                    word_d        = head[rr_ptr_q];
                    pop[rr_ptr_q] = 1'b1;
                    beat_d        = beat_q + 1'b1;
                    if (beat_d == BW'(FRAME_LEN)) begin
                        state_d = SLOT;
                    end
                end
                default: state_d = SLOT;
            endcase

            sync_pend_d = (pend_clr ? 1'b0 : sync_pend_q) |
                          (sync_cnt_d == SW'(SYNC_PERIOD - 1));
        end
    end

    // A new overflow in the same cycle as a clear leaves the flag set.
    assign ovf_d = (ovf_clr_i ? '0 : ovf_q) | (wr_cmd_i & fifo_full_o);

    always_ff @(posedge clk40 or posedge rst) begin
        if (rst) begin
            state_q     <= SLOT;
            rr_ptr_q    <= CH_W'(NUM_CH - 1);
            beat_q      <= '0;
            sync_cnt_q  <= '0;
            sync_pend_q <= 1'b0;
            word_q      <= SYNC_WORD;
            valid_q     <= 1'b0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_q      <= beat_d;
            sync_cnt_q  <= sync_cnt_d;
            sync_pend_q <= sync_pend_d;
            word_q      <= word_d;
            valid_q     <= 1'b1;
            ovf_q       <= ovf_d;
        end
    end

    assign word_out_o   = word_q;
    assign word_valid_o = valid_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_cmd_stream_arbiter.sv
// Two arbiters (FRAME_LEN 1 and 2) on shared stimulus, checked each cycle against a queue-based model.
module tb_cmd_stream_arbiter;

    localparam logic [15:0] SYNC = 16'h817E;
    localparam logic [15:0] IDLE = 16'hAAAA;

    logic        clk40;
    logic        rst;
    logic [3:0]  wr_cmd;
    logic [63:0] datain;
    logic [3:0]  ch_enable;
    logic        ovf_clr;
    logic        word_ready;

    logic [3:0]  d_full  [2];
    logic [3:0]  d_empty [2];
    logic [3:0]  d_ovf   [2];
    logic [15:0] d_word  [2];
    logic        d_valid [2];

    int checks = 0;
    int errors = 0;

    cmd_stream_arbiter #(.FRAME_LEN(1)) u_dut0 (
        .clk40(clk40), .rst(rst), .wr_cmd_i(wr_cmd), .datain_i(datain),
        .ch_enable_i(ch_enable), .ovf_clr_i(ovf_clr),
        .fifo_full_o(d_full[0]), .fifo_empty_o(d_empty[0]), .overflow_o(d_ovf[0]),
        .word_out_o(d_word[0]), .word_valid_o(d_valid[0]), .word_ready_i(word_ready)
    );

    cmd_stream_arbiter #(.FRAME_LEN(2)) u_dut1 (
        .clk40(clk40), .rst(rst), .wr_cmd_i(wr_cmd), .datain_i(datain),
        .ch_enable_i(ch_enable), .ovf_clr_i(ovf_clr),
        .fifo_full_o(d_full[1]), .fifo_empty_o(d_empty[1]), .overflow_o(d_ovf[1]),
        .word_out_o(d_word[1]), .word_valid_o(d_valid[1]), .word_ready_i(word_ready)
    );

    initial clk40 = 1'b0;
    always #5 clk40 = ~clk40;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%h required=%h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Model: per-channel queues, a slot counter and "words left in the current frame".
    logic [15:0] mq [2][4][$];
    logic [15:0] m_word  [2];
    bit          m_valid [2];
    int          m_cnt   [2];
    bit          m_pend  [2];
    int          m_last  [2];
    int          m_left  [2];
    int          m_fch   [2];
    logic [3:0]  m_ovf   [2];
    bit          m_fullpre [4];
    bit          m_found;
    int          m_fl, m_c;

    always @(posedge clk40 or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 4; c++) mq[d][c].delete();
                m_word[d]  = SYNC;
                m_valid[d] = 1'b0;
                m_cnt[d]   = 0;
                m_pend[d]  = 1'b0;
                m_last[d]  = 3;
                m_left[d]  = 0;
                m_fch[d]   = 0;
                m_ovf[d]   = 4'h0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_fl = (d == 0) ? 1 : 2;
                for (int c = 0; c < 4; c++) m_fullpre[c] = (mq[d][c].size() == 16);
                if (m_valid[d] && word_ready) begin
                    m_cnt[d] = (m_cnt[d] + 1) % 32;
                    if (m_left[d] > 0) begin
                        m_word[d] = mq[d][m_fch[d]].pop_front();
                        m_left[d]--;
                    end else if (m_pend[d]) begin
                        m_word[d] = SYNC;
                        m_pend[d] = 1'b0;
                    end else begin
                        m_found = 1'b0;
                        for (int k = 1; k <= 4; k++) begin
                            m_c = (m_last[d] + k) % 4;
                            if (!m_found && ch_enable[m_c] && mq[d][m_c].size() >= m_fl) begin
                                m_found   = 1'b1;
                                m_word[d] = mq[d][m_c].pop_front();
                                m_last[d] = m_c;
                                m_fch[d]  = m_c;
                                m_left[d] = m_fl - 1;
                            end
                        end
                        if (!m_found) m_word[d] = IDLE;
                    end
                    if (m_cnt[d] == 31) m_pend[d] = 1'b1;
                end
                if (ovf_clr) m_ovf[d] = 4'h0;
                for (int c = 0; c < 4; c++) begin
                    if (wr_cmd[c]) begin
                        if (m_fullpre[c]) m_ovf[d][c] = 1'b1;
                        else mq[d][c].push_back(datain[c*16 +: 16]);
                    end
                end
                m_valid[d] = 1'b1;
            end
        end
    end

    logic [3:0] cmp_full, cmp_empty;

    always @(negedge clk40) begin
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                cmp_full[c]  = (mq[d][c].size() == 16);
                cmp_empty[c] = (mq[d][c].size() == 0);
            end
            chk("word_out",   d, d_word[d],  m_word[d]);
            chk("word_valid", d, d_valid[d], m_valid[d]);
            chk("fifo_full",  d, d_full[d],  cmp_full);
            chk("fifo_empty", d, d_empty[d], cmp_empty);
            chk("overflow",   d, d_ovf[d],   m_ovf[d]);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk40);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; wr_cmd = 4'h0; datain = '0; ch_enable = 4'hF;
        ovf_clr = 1'b0; word_ready = 1'b0;
        tick(3);
        chk("lit_rst_word",  0, d_word[0],  SYNC);
        chk("lit_rst_valid", 1, d_valid[1], 1'b0);
        chk("lit_rst_empty", 0, d_empty[0], 4'hF);
        rst = 1'b0; word_ready = 1'b1;
        tick(1);
        chk("lit_first_valid", 0, d_valid[0], 1'b1);
        chk("lit_first_word",  1, d_word[1],  SYNC);

        // Idle stream; ch1 gets two words so the 2-word frame straddles the due SYNC.
        tick(28);
        chk("lit_idle", 0, d_word[0], IDLE);
        wr_cmd = 4'b0010; datain[16 +: 16] = 16'h1111;
        tick(1);
        datain[16 +: 16] = 16'h1112;
        tick(1);
        wr_cmd = 4'h0;
        chk("lit_f1_w0", 0, d_word[0], 16'h1111);
        chk("lit_f2_idle", 1, d_word[1], IDLE);
        tick(1);
        chk("lit_f1_w1", 0, d_word[0], 16'h1112);
        chk("lit_f2_w0", 1, d_word[1], 16'h1111);
        tick(1);
        chk("lit_f1_sync", 0, d_word[0], SYNC);
        chk("lit_f2_w1",   1, d_word[1], 16'h1112);
        tick(1);
        chk("lit_f2_sync", 1, d_word[1], SYNC);

        // Ch0 burst 0x000B..0x0010.
        for (int k = 0; k < 6; k++) begin
            wr_cmd = 4'b0001; datain[15:0] = 16'(16'h000B + k);
            tick(1);
        end
        wr_cmd = 4'h0;
        tick(1);
        chk("lit_burst_last", 0, d_word[0], 16'h0010);
        tick(1);
        chk("lit_burst_idle", 0, d_word[0], IDLE);
        chk("lit_burst_f2",   1, d_word[1], 16'h0010);

        // Ch2 overflow with the link stalled.
        word_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            wr_cmd = 4'b0100; datain[32 +: 16] = 16'(16'h2000 + k);
            tick(1);
            if (k == 15) chk("lit_full16", 0, d_full[0], 4'b0100);
        end
        wr_cmd = 4'h0;
        chk("lit_ovf_set", 1, d_ovf[1], 4'b0100);
        tick(1);
        chk("lit_ovf_sticky", 0, d_ovf[0], 4'b0100);
        wr_cmd = 4'b0100; datain[32 +: 16] = 16'h2FFF; ovf_clr = 1'b1;
        tick(1);
        chk("lit_ovf_setwins", 0, d_ovf[0], 4'b0100);
        wr_cmd = 4'h0;
        tick(1);
        chk("lit_ovf_clr", 0, d_ovf[0], 4'b0000);
        ovf_clr = 1'b0; word_ready = 1'b1;
        tick(1);
        chk("lit_drain_first", 0, d_word[0], 16'h2000);
        tick(15);
        chk("lit_drain_last", 0, d_word[0], 16'h200F);
        chk("lit_drain_last", 1, d_word[1], 16'h200F);
        chk("lit_drain_empty", 1, d_empty[1], 4'hF);

        // Ch3 with word_ready toggling.
        for (int k = 0; k < 4; k++) begin
            word_ready = (k % 2 == 0);
            wr_cmd = 4'b1000; datain[48 +: 16] = 16'(16'h3000 + k);
            tick(1);
        end
        wr_cmd = 4'h0; word_ready = 1'b1;
        tick(6);

        // Reset while the FRAME_LEN=2 instance is mid-frame.
        word_ready = 1'b0;
        wr_cmd = 4'b1000; datain[48 +: 16] = 16'h3100;
        tick(1);
        datain[48 +: 16] = 16'h3101;
        tick(1);
        wr_cmd = 4'h0; word_ready = 1'b1;
        tick(1);
        @(posedge clk40);
        #3 rst = 1'b1;
        #1;
        chk("lit_midrst_word",  1, d_word[1],  SYNC);
        chk("lit_midrst_valid", 1, d_valid[1], 1'b0);
        chk("lit_midrst_empty", 1, d_empty[1], 4'hF);
        word_ready = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);

        // All channels saturated.
        for (int k = 0; k < 100; k++) begin
            for (int c = 0; c < 4; c++) datain[c*16 +: 16] = 16'(32'h1000 * (c + 1) + k);
            wr_cmd = 4'hF;
            word_ready = (k >= 4);
            ch_enable = (k >= 40 && k < 46) ? 4'b1101 : 4'hF;
            tick(1);
            if (k == 4) begin
                chk("lit_sat0", 0, d_word[0], 16'h1000);
                chk("lit_sat0", 1, d_word[1], 16'h1000);
            end
            if (k == 5) begin
                chk("lit_sat1", 0, d_word[0], 16'h2000);
                chk("lit_sat1", 1, d_word[1], 16'h1001);
            end
            if (k == 7) chk("lit_sat3", 0, d_word[0], 16'h4000);
            if (k == 8) begin
                chk("lit_sat4", 0, d_word[0], 16'h1001);
                chk("lit_sat4", 1, d_word[1], 16'h3000);
            end
        end
        wr_cmd = 4'h0;
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_stream_arbiter.md
Name: cmd_stream_arbiter

Overview:
Multi-channel command source for the chip command link, running entirely in the clk40 domain. NUM_CH independent producers each write DATA_W-bit command words into a private FIFO. The block then arbitrates between channels round-robin, in frames of FRAME_LEN words. It emits one word per downstream slot and inserts a SYNC word every SYNC_PERIOD slots and an IDLE word when no channel is eligible. Output feeds the existing clk160/clk640 serializer through a word_valid/word_ready handshake.

Parameters:
NUM_CH, 4, number of producer channels (1..8)
DATA_W, 16, command word width
FIFO_DEPTH, 16, words per channel FIFO (power of 2, >= FRAME_LEN)
FRAME_LEN, 1, words emitted atomically per grant (1..FIFO_DEPTH)
SYNC_PERIOD, 32, slots between SYNC words (>= 2)
SYNC_WORD, 16'h817E, sync pattern (DATA_W bits)
IDLE_WORD, 16'hAAAA, idle pattern (DATA_W bits)

Ports:
clk40  in  1  system clock, 40 MHz
rst  in  1  asynchronous, active-high reset
wr_cmd  in  NUM_CH  per-channel write strobe
datain  in  NUM_CH*DATA_W  per-channel data; channel i at [i*DATA_W +: DATA_W]
ch_enable  in  NUM_CH  channel may be granted when 1
ovf_clr  in  1  clears all overflow flags
fifo_full  out  NUM_CH  per-channel full (count == FIFO_DEPTH)
fifo_empty  out  NUM_CH  per-channel empty
overflow  out  NUM_CH  sticky: write attempted while full
word_out  out  DATA_W  current output word
word_valid  out  1  word_out holds a defined word
word_ready  in  1  serializer consumes word_out this cycle

Behaviour:
- Reset (async assert, sync release on clk40): all FIFOs empty, fifo_empty all 1, fifo_full 0, overflow 0, word_out = SYNC_WORD, word_valid = 0, sync_cnt = 0, rr_ptr = NUM_CH-1, state = SLOT. First posedge after release sets word_valid = 1. It stays 1 until the next reset.
- FIFO write: wr_cmd[i] & !fifo_full[i] pushes datain[i] at posedge. wr_cmd[i] & fifo_full[i] drops the word and sets overflow[i]. Full is the registered value, so a same-cycle pop does not admit the write.
- Simultaneous push and pop on the same channel: both occur; count unchanged.
- ovf_clr clears overflow. If ovf_clr and a new overflow occur in the same cycle, the flag is set (set wins).
- Slot: a cycle with word_valid & word_ready. Only slots advance sync_cnt, the FSM and the pops. The next word appears on word_out at the same posedge, with zero bubble.
- sync_cnt increments every slot, wrapping SYNC_PERIOD-1 -> 0. When it reaches SYNC_PERIOD-1, sync_pend is set.
- FSM, evaluated per slot:
  - SLOT: if sync_pend, emit SYNC_WORD and clear sync_pend.
  - SLOT: else, if any channel i has ch_enable[i] & count[i] >= FRAME_LEN, grant the first such channel searching from rr_ptr+1 with wrap. Emit its head word, pop it, set rr_ptr = i and beat = 1. If FRAME_LEN > 1, go to FRAME.
  - SLOT: else emit IDLE_WORD.
  - FRAME: emit the head of the granted channel, pop it, beat++. At beat == FRAME_LEN, return to SLOT.
  - FRAME: SYNC is deferred, never splits a frame. ch_enable deassertion mid-frame does not abort the frame.
- Frame eligibility requires FRAME_LEN words already stored, so a frame can never underflow.
- Latency: a word written into an empty FIFO at posedge N can be emitted on word_out at posedge N+1 at the earliest, given a slot, no sync due, and the channel winning arbitration.
- Fairness: with all channels saturated, grants rotate 0,1,..,NUM_CH-1,0. No channel waits more than NUM_CH-1 frames plus one SYNC.
- Reset mid-frame: frame abandoned, FIFO contents lost, output returns to the reset state.

Decomposition:
- Package cmd_stream_pkg: default SYNC_WORD/IDLE_WORD constants, FSM state typedef {SLOT, FRAME}, and a clog2-based count-width function.
- Sub-module cmd_fifo_sync: single-clock FIFO with registered full/empty and count output, instantiated NUM_CH times.
- The arbiter/FSM lives in the top level.

Test Plan:
- Reset then word_ready=1 held, no writes -> word_out: SYNC_WORD at reset, then IDLE_WORD in every slot, with SYNC_WORD at slot 31, 63, 95 (SYNC_PERIOD=32).
- Ch0 writes 0x000B..0x0010, others idle, word_ready=1 -> words 0x000B..0x0010 appear in order, first one posedge after the write, then IDLE.
- All 4 channels saturated, FRAME_LEN=1 -> grant order 0,1,2,3,0,..; per-channel words strictly in order; SYNC every 32nd slot.
- FRAME_LEN=2, ch1 holds 2 words and sync falls due mid-frame -> both ch1 words are consecutive, then SYNC_WORD, with no split.
- Ch2 receives 17 writes with word_ready=0 -> fifo_full[2]=1 after 16, 17th dropped, overflow[2]=1 until ovf_clr; 16 words drain correctly afterwards.
- word_ready toggled 1,0,1,0 with ch3 data -> word_out holds while word_ready=0; no pop, no sync_cnt advance; rst mid-frame -> word_out=SYNC_WORD, word_valid=0, fifo_empty=all 1.
